// File: rtl/vga_sync_receiver.sv
`default_nettype none
// ============================================================================
// vga_sync_receiver : VGA sink that recovers X/Y from HS/VS, checks sync
//                     timing, streams active pixels and captures a probe pixel.
// Revision          : 1.0
// ============================================================================
module vga_sync_receiver #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        hs,
  input  logic        vs,
  input  logic [11:0] color_in,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic        pix_valid,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [11:0] pix_color,
  output logic [11:0] probe_color,
  output logic        probe_hit,
  output logic        frame_done,
  output logic        locked,
  output logic        sync_err,
  output logic [7:0]  err_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] C_H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] C_V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] C_H_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] C_H_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] C_V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] C_V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0] C_CNT_MAX = 10'h3FF;

  typedef enum logic [1:0] {
    ACQ_H = 2'd0,
    ACQ_V = 2'd1,
    CHECK = 2'd2,
    LOCK  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_hs_q, r_hs_qq, r_vs_q, r_vs_qq;
  logic [9:0]  r_hcnt, r_vcnt;
  logic [9:0]  r_probe_x, r_probe_y;
  logic        r_pix_valid, r_probe_hit, r_frame_done, r_locked, r_sync_err;
  logic [9:0]  r_x, r_y;
  logic [11:0] r_pix_color, r_probe_color;
  logic [7:0]  r_err_cnt;

  logic       w_hs_act, w_vs_act, w_hs_start, w_vs_start;
  logic       w_checking, w_violation, w_active, w_emit;
  logic [9:0] w_x, w_y;

  assign w_hs_act   = (hs == SYNC_POL);
  assign w_vs_act   = (vs == SYNC_POL);
  assign w_hs_start = r_hs_q & ~r_hs_qq;
  assign w_vs_start = r_vs_q & ~r_vs_qq;

  // Several faults in the same tick collapse into one violation event.
  assign w_checking  = (r_state == CHECK) || (r_state == LOCK);
  assign w_violation = w_checking &&
                       ((w_hs_start && (r_hcnt != C_H_LAST)) ||
                        (r_hcnt == C_CNT_MAX) ||
                        (w_vs_start && (r_vcnt != C_V_LAST)) ||
                        (r_vcnt == C_CNT_MAX));

  assign w_active = (r_hcnt >= C_H_START) && (r_hcnt < C_H_END) &&
                    (r_vcnt >= C_V_START) && (r_vcnt < C_V_END);
  assign w_x      = r_hcnt - C_H_START;
  assign w_y      = r_vcnt - C_V_START;
  assign w_emit   = (r_state == LOCK) && w_active && !w_violation;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ACQ_H;
      r_hs_q        <= 1'b0;
      r_hs_qq       <= 1'b0;
      r_vs_q        <= 1'b0;
      r_vs_qq       <= 1'b0;
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_probe_x     <= '0;
      r_probe_y     <= '0;
      r_pix_valid   <= 1'b0;
      r_probe_hit   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_locked      <= 1'b0;
      r_sync_err    <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_pix_color   <= '0;
      r_probe_color <= '0;
      r_err_cnt     <= '0;
    end else begin
      r_pix_valid  <= 1'b0;
      r_probe_hit  <= 1'b0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      if (pix_en) begin
        r_hs_q    <= w_hs_act;
        r_hs_qq   <= r_hs_q;
        r_vs_q    <= w_vs_act;
        r_vs_qq   <= r_vs_q;
        r_probe_x <= probe_x;
        r_probe_y <= probe_y;

        // Counters saturate rather than wrap so a lost sync is detectable.
        if (w_hs_start)
          r_hcnt <= '0;
        else if (r_hcnt != C_CNT_MAX)
          r_hcnt <= r_hcnt + 10'd1;

        if (w_vs_start)
          r_vcnt <= '0;
        else if (w_hs_start && (r_vcnt != C_CNT_MAX))
          r_vcnt <= r_vcnt + 10'd1;

        if (w_violation) begin
          r_sync_err <= 1'b1;
          r_state    <= ACQ_H;
          r_locked   <= 1'b0;
          if (r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
        end else begin
          case (r_state)
            ACQ_H: if (w_hs_start) r_state <= ACQ_V;
            ACQ_V: if (w_vs_start) r_state <= CHECK;
            CHECK: if (w_vs_start) begin
              r_state  <= LOCK;
              r_locked <= 1'b1;
            end
            LOCK:  if (w_vs_start) r_frame_done <= 1'b1;
            default: r_state <= ACQ_H;
          endcase
        end

        if (w_emit) begin
          r_pix_valid <= 1'b1;
          r_x         <= w_x;
          r_y         <= w_y;
          r_pix_color <= color_in;
          if ((w_x == r_probe_x) && (w_y == r_probe_y)) begin
            r_probe_color <= color_in;
            r_probe_hit   <= 1'b1;
          end
        end
      end
    end
  end

  assign pix_valid   = r_pix_valid;
  assign x           = r_x;
  assign y           = r_y;
  assign pix_color   = r_pix_color;
  assign probe_color = r_probe_color;
  assign probe_hit   = r_probe_hit;
  assign frame_done  = r_frame_done;
  assign locked      = r_locked;
  assign sync_err    = r_sync_err;
  assign err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_receiver.sv
`default_nettype none
// ============================================================================
// tb_vga_sync_receiver : directed self-checking bench on a reduced 16x9 timing.
// Revision             : 1.0
// ============================================================================
module tb_vga_sync_receiver;

  localparam int HA = 8, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 4, VFP = 1, VSW = 2, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;   // 16
  localparam int VT = VA + VFP + VSW + VBP;   // 9
  // hcnt trails the line position by two ticks (sync register + edge detect).
  localparam int PX0 = HSW + HBP + 2;
  localparam int LY0 = VSW + VBP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic        hs = 1'b1;
  logic        vs = 1'b1;
  logic [11:0] color_in = '0;
  logic [9:0]  probe_x = 10'd5;
  logic [9:0]  probe_y = 10'd2;
  logic        pix_valid, probe_hit, frame_done, locked, sync_err;
  logic [9:0]  x, y;
  logic [11:0] pix_color, probe_color;
  logic [7:0]  err_cnt;

  vga_sync_receiver #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hs(hs), .vs(vs),
    .color_in(color_in), .probe_x(probe_x), .probe_y(probe_y),
    .pix_valid(pix_valid), .x(x), .y(y), .pix_color(pix_color),
    .probe_color(probe_color), .probe_hit(probe_hit), .frame_done(frame_done),
    .locked(locked), .sync_err(sync_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int p = 0, l = 0;
  bit kill = 1'b0;
  int n_valid, n_hit, n_done, n_err, n_stale;
  bit got_first;
  logic [9:0]  first_x, first_y, last_x, last_y;
  logic [11:0] first_col;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_valid = 0; n_hit = 0; n_done = 0; n_err = 0; n_stale = 0;
    got_first = 1'b0;
    first_x = '0; first_y = '0; first_col = '0; last_x = '0; last_y = '0;
  endtask

  // One pixel tick: PIX_EN high for one CLK out of four.
  task automatic drive_tick(input bit hs_act, input bit vs_act, input logic [11:0] col);
    @(negedge clk);
    hs = ~hs_act;
    vs = ~vs_act;
    color_in = col;
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    if (pix_valid) begin
      n_valid++;
      if (!got_first) begin
        got_first = 1'b1; first_x = x; first_y = y; first_col = pix_color;
      end
      last_x = x; last_y = y;
    end
    if (probe_hit)  n_hit++;
    if (frame_done) n_done++;
    if (sync_err)   n_err++;
    @(negedge clk);
    if (pix_valid || probe_hit || frame_done || sync_err) n_stale++;
    @(negedge clk);
  endtask

  task automatic gen_tick();
    logic [11:0] col;
    col = '0;
    if (l >= LY0 && l < LY0 + VA && p >= PX0 && p < PX0 + HA)
      col = 12'hC00 | 12'(((l - LY0) << 4) | (p - PX0));
    drive_tick(!kill && (p < HSW), !kill && (l < VSW), col);
    p++;
    if (p == HT) begin
      p = 0;
      l++;
      if (l == VT) l = 0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) gen_tick();
  endtask

  initial begin
    clear_counts();
    repeat (3) @(negedge clk);
    chk("rst_locked", locked, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_probe_color", probe_color, 0);
    chk("rst_sync_err", sync_err, 0);
    rst_n = 1'b1;

    // Acquisition from mid-frame: lock at the second VS start edge.
    p = 5; l = 3;
    clear_counts();
    run(236);
    chk("acq_not_locked_early", locked, 0);
    chk("acq_no_err", n_err, 0);
    run(1);
    chk("acq_locked", locked, 1);

    // One full locked frame.
    clear_counts();
    run(HT * VT);
    chk("frame_valid_count", n_valid, HA * VA);
    chk("frame_done_count", n_done, 1);
    chk("frame_err_count", n_err, 0);
    chk("frame_first_x", first_x, 0);
    chk("frame_first_y", first_y, 0);
    chk("frame_first_color", first_col, 12'hC00);
    chk("frame_last_x", last_x, 7);
    chk("frame_last_y", last_y, 3);
    chk("frame_color_hold", pix_color, 12'hC37);
    chk("probe_hit_count", n_hit, 1);
    chk("probe_color", probe_color, 12'hC25);
    chk("frame_err_cnt", err_cnt, 0);
    chk("pulses_one_clk", n_stale, 0);

    // Short line while locked.
    run(35);
    p = p + 1;
    clear_counts();
    run(12);
    chk("short_line_err_pulse", n_err, 1);
    chk("short_line_err_cnt", err_cnt, 1);
    chk("short_line_unlocked", locked, 0);
    clear_counts();
    run(239);
    chk("relock_not_early", locked, 0);
    chk("relock_no_pixels", n_valid, 0);
    run(1);
    chk("relock_locked", locked, 1);
    chk("relock_no_err", n_err, 0);

    // Sync lost: only the hcnt==1023 tick flags.
    kill = 1'b1;
    clear_counts();
    run(1023);
    chk("hs_lost_no_early_err", n_err, 0);
    chk("hs_lost_still_locked", locked, 1);
    run(1);
    chk("hs_lost_err_pulse", n_err, 1);
    chk("hs_lost_unlocked", locked, 0);
    chk("hs_lost_err_cnt", err_cnt, 2);
    run(76);
    chk("hs_lost_single_err", n_err, 1);

    // Repeated violations: HS edge, VS edge -> CHECK, premature VS edge.
    clear_counts();
    for (int i = 0; i < 300; i++) begin
      drive_tick(1'b1, 1'b0, 12'h000);
      drive_tick(1'b0, 1'b1, 12'h000);
      drive_tick(1'b0, 1'b0, 12'h000);
      drive_tick(1'b0, 1'b1, 12'h000);
      drive_tick(1'b0, 1'b0, 12'h000);
    end
    chk("sat_err_pulses", n_err, 300);
    chk("sat_err_cnt", err_cnt, 8'hFF);
    chk("sat_unlocked", locked, 0);

    // Relock, then asynchronous reset mid-frame.
    kill = 1'b0;
    p = 5; l = 3;
    clear_counts();
    run(236);
    chk("pre_rst_not_locked", locked, 0);
    run(1);
    chk("pre_rst_locked", locked, 1);
    run(88);
    chk("pre_rst_x", x, 1);
    chk("pre_rst_y", y, 1);
    chk("pre_rst_err_cnt", err_cnt, 8'hFF);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_locked", locked, 0);
    chk("async_rst_err_cnt", err_cnt, 0);
    chk("async_rst_x", x, 0);
    chk("async_rst_y", y, 0);
    chk("async_rst_pix_color", pix_color, 0);
    chk("async_rst_probe_color", probe_color, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    p = 5; l = 3;
    clear_counts();
    run(236);
    chk("post_rst_not_locked", locked, 0);
    run(1);
    chk("post_rst_locked", locked, 1);
    chk("post_rst_err_cnt", err_cnt, 0);
    chk("post_rst_no_err", n_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Sink end of the VGA link: consumes HS, VS and the 12-bit colour bus driven by the VGA controller, recovers pixel coordinates and checks sync timing.
- Streams active pixels with X/Y and captures one pixel at a programmable probe coordinate.
- Used as a self-checking monitor in simulation and as an on-board loopback checker next to the controller.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixel ticks)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
SYNC_POL, 0, active level of HS/VS (0 = active-low)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-low
PIX_EN  in  1  pixel-tick enable, one CLK wide; all sampling happens only on ticks
HS  in  1  horizontal sync from controller
VS  in  1  vertical sync from controller
COLOR_IN  in  12  pixel colour from controller
PROBE_X  in  10  probe column
PROBE_Y  in  10  probe row
PIX_VALID  out  1  active pixel on X/Y/PIX_COLOR, one CLK wide
X  out  10  column of current pixel
Y  out  10  row of current pixel
PIX_COLOR  out  12  registered COLOR_IN
PROBE_COLOR  out  12  colour captured at (PROBE_X, PROBE_Y)
PROBE_HIT  out  1  one-CLK pulse when PROBE_COLOR updates
FRAME_DONE  out  1  one-CLK pulse at each VS start edge while LOCK
LOCKED  out  1  timing verified
SYNC_ERR  out  1  one-CLK pulse on any timing violation
ERR_CNT  out  8  saturating violation count

Behaviour:
- Derived: H_TOTAL = sum of H params (800), V_TOTAL = sum of V params (525). hs_a = (HS == SYNC_POL), vs_a likewise.
- On each PIX_EN: register hs_a/vs_a; start edge = inactive->active transition of the registered value.
- hcnt (10 b): cleared to 0 on the tick after HS start edge, else +1, saturates at 1023 (no wrap). vcnt (10 b): +1 on each HS start edge; VS start edge wins and clears to 0.
- Active region: H_SYNC+H_BP <= hcnt < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= vcnt < V_SYNC+V_BP+V_ACTIVE. X = hcnt-(H_SYNC+H_BP), Y = vcnt-(V_SYNC+V_BP).
- FSM:
  - ACQ_H: waits for an HS start edge -> ACQ_V.
  - ACQ_V: waits for a VS start edge -> CHECK.
  - CHECK: runs one frame with checks; at the next VS start edge with vcnt == V_TOTAL-1 and no violation -> LOCK.
  - LOCK: LOCKED = 1.
  - Any violation in CHECK/LOCK -> ACQ_H.
- Violations, checked in CHECK/LOCK only:
  - HS start edge with hcnt != H_TOTAL-1.
  - hcnt reaching 1023 (HS lost).
  - VS start edge with vcnt != V_TOTAL-1.
  - vcnt reaching 1023.
  - Response to each: SYNC_ERR pulse, ERR_CNT+1 saturating at 255, LOCKED drops the same cycle the FSM leaves LOCK.
  - Simultaneous violations in one tick count once.
- Outputs (only in LOCK, from the tick sampling an active-region pixel):
  - PIX_VALID, X, Y, PIX_COLOR register 1 CLK after that PIX_EN cycle; PIX_VALID is high for exactly that one cycle.
  - X/Y/PIX_COLOR hold between pulses.
- Probe: in LOCK, when the active pixel has X==PROBE_X and Y==PROBE_Y, PROBE_COLOR loads that colour and PROBE_HIT pulses, same cycle as PIX_VALID. Probe coordinates are sampled each tick; a change takes effect on the next tick.
- PIX_EN low: all state frozen, pulses deasserted.
- Reset values (RST low, any time incl. mid-frame): state ACQ_H; all counters, X, Y, PIX_COLOR, PROBE_COLOR, ERR_CNT = 0; PIX_VALID, PROBE_HIT, FRAME_DONE, SYNC_ERR, LOCKED = 0; sync history registers = inactive level.

Test Plan:
- Nominal 640x480 controller, PIX_EN every 4th CLK, RST released -> LOCKED rises at the second VS start edge seen; then 307200 PIX_VALID pulses per frame, FRAME_DONE once per frame, ERR_CNT stays 0.
- Constant pattern COLOR_IN=12'hABC in active area -> first PIX_VALID after lock has X=0, Y=0, PIX_COLOR=ABC; last pulse in the frame has X=639, Y=479.
- Probe (320,240) with controller drawing 12'h0F0 there -> one PROBE_HIT per frame, PROBE_COLOR=12'h0F0.
- One 799-tick line injected while locked -> one SYNC_ERR pulse, ERR_CNT=1, LOCKED=0, PIX_VALID silent until relock one full frame later.
- HS held inactive 1100 ticks while locked -> exactly one SYNC_ERR at hcnt=1023, ERR_CNT+1; then 300 injected violations -> ERR_CNT saturates at 255.
- RST pulsed low mid-frame while locked -> all outputs 0 immediately (asynchronous), FSM ACQ_H, relock after the same acquisition sequence as power-up.
